multiplier8_signed: RTL and testbench

- Sequential 8x8 two's-complement shift-add multiplier for the board-level lab top.
- Multiplier B is loaded from switches SW by the Reset_Load_Clear button. The multiplicand S is read live from SW.
- The Run button starts the operation. The 16-bit product ends up in A:B, with X holding the sign extension.
- A, B and X go to LEDs; A and B are also shown on four seven-segment displays.

---
 rtl/mult8_pkg.sv | 21 ++
 rtl/hex_seg_decoder.sv | 15 +
 rtl/multiplier8_signed.sv | 128 ++++++++++++
 tb/tb_multiplier8_signed.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult8_pkg.sv
// Shared types and constants for the 8x8 signed shift-add multiplier.
// Holds the control state encoding, operand width and seven-segment lookup.
package mult8_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // Active-low {dp,g..a} glyphs, entry 15 first so SEG_LUT[n] is nibble n.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_seg_decoder.sv
// Nibble to active-low seven-segment glyph, decimal point held off.
// Purely combinational, zero latency, no flow control.
module hex_seg_decoder
  import mult8_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  logic [7:0] glyph;

  assign glyph = SEG_LUT[nibble_i];
  assign seg_o = {1'b1, glyph[6:0]};

endmodule

// File: rtl/multiplier8_signed.sv
// Sequential 8x8 two's-complement shift-add multiplier, product in {A,B}, sign in X.
// Result settles 11 clocks after Run falls (2 sync + 1 start + 8 compute); no backpressure.
module multiplier8_signed
  import mult8_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Reset_Load_Clear,
  input  logic [WIDTH-1:0] SW,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [7:0]       HEX0,
  output logic [7:0]       HEX1,
  output logic [7:0]       HEX2,
  output logic [7:0]       HEX3
);

  logic run_meta_q, run_sync_q;
  logic rlc_meta_q, rlc_sync_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;

  logic [WIDTH:0]   opnd_a, opnd_s, sum9;
  logic             sub_op;

  // Buttons idle high, so the synchronizers reset to the released level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_meta_q <= 1'b1;
      run_sync_q <= 1'b1;
      rlc_meta_q <= 1'b1;
      rlc_sync_q <= 1'b1;
    end else begin
      run_meta_q <= Run;
      run_sync_q <= run_meta_q;
      rlc_meta_q <= Reset_Load_Clear;
      rlc_sync_q <= rlc_meta_q;
    end
  end

  // The final partial product carries the multiplier's sign bit, so it is subtracted.
  always_comb begin
    opnd_a = {a_q[WIDTH-1], a_q};
    opnd_s = {SW[WIDTH-1], SW};
    sub_op = (count_q == LAST_CNT);
    sum9   = sub_op ? (opnd_a - opnd_s) : (opnd_a + opnd_s);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;

    case (state_q)
      IDLE: begin
        if (!rlc_sync_q) begin
          b_d = SW;
          a_d = '0;
          x_d = 1'b0;
        end else if (!run_sync_q) begin
          a_d     = '0;
          x_d     = 1'b0;
          count_d = '0;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        if (b_q[0]) begin
          x_d = sum9[WIDTH];
          a_d = sum9[WIDTH:1];
          b_d = {sum9[0], b_q[WIDTH-1:1]};
        end else begin
          a_d = {x_q, a_q[WIDTH-1:1]};
          b_d = {a_q[0], b_q[WIDTH-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (run_sync_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
    end
  end

  assign X    = x_q;
  assign Aval = a_q;
  assign Bval = b_q;

  hex_seg_decoder u_hex0 (.nibble_i(b_q[3:0]), .seg_o(HEX0));
  hex_seg_decoder u_hex1 (.nibble_i(b_q[7:4]), .seg_o(HEX1));
  hex_seg_decoder u_hex2 (.nibble_i(a_q[3:0]), .seg_o(HEX2));
  hex_seg_decoder u_hex3 (.nibble_i(a_q[7:4]), .seg_o(HEX3));

endmodule

// File: tb/tb_multiplier8_signed.sv
// Scoreboard bench: driver pushes expected {A,B,X,HEX} from an integer product model,
// a negedge monitor pops and compares whenever the driver requests a sample.
module tb_multiplier8_signed;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       Reset_Load_Clear;
  logic [7:0] SW;
  logic       X;
  logic [7:0] Aval, Bval;
  logic [7:0] HEX0, HEX1, HEX2, HEX3;

  multiplier8_signed dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Run              (Run),
    .Reset_Load_Clear (Reset_Load_Clear),
    .SW               (SW),
    .X                (X),
    .Aval             (Aval),
    .Bval             (Bval),
    .HEX0             (HEX0),
    .HEX1             (HEX1),
    .HEX2             (HEX2),
    .HEX3             (HEX3)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        x;
    logic [31:0] hex;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  logic sample_req;
  int   checks;
  int   errors;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [15:0] prod, input logic x, input string tag);
    exp_t e;
    e.a   = prod[15:8];
    e.b   = prod[7:0];
    e.x   = x;
    e.hex = {glyph(prod[15:12]), glyph(prod[11:8]), glyph(prod[7:4]), glyph(prod[3:0])};
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] b, input logic [7:0] s, input string tag);
    int bi, si, p;
    bi = int'($signed(b));
    si = int'($signed(s));
    p  = bi * si;
    return make_exp(16'(p), p < 0, tag);
  endfunction

  // Monitor: compares the DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sample_req) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: sample requested with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (Aval !== e.a) begin
            errors++; $display("FAIL %s A: got %02h want %02h", e.tag, Aval, e.a);
          end
          checks++;
          if (Bval !== e.b) begin
            errors++; $display("FAIL %s B: got %02h want %02h", e.tag, Bval, e.b);
          end
          checks++;
          if (X !== e.x) begin
            errors++; $display("FAIL %s X: got %0b want %0b", e.tag, X, e.x);
          end
          checks++;
          if ({HEX3, HEX2, HEX1, HEX0} !== e.hex) begin
            errors++;
            $display("FAIL %s HEX3..0: got %08h want %08h", e.tag, {HEX3, HEX2, HEX1, HEX0}, e.hex);
          end
        end
        sample_req = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic request(input exp_t e);
    exp_q.push_back(e);
    sample_req = 1'b1;
    for (int i = 0; i < 4 && sample_req; i++) begin
      @(negedge Clk);
      #1;
    end
    if (sample_req) begin
      checks++; errors++;
      $display("FAIL %s monitor_timeout: got no sample want sample within 4 cycles", e.tag);
      sample_req = 1'b0;
    end
  endtask

  task automatic load_b(input logic [7:0] b);
    SW = b;
    Reset_Load_Clear = 1'b0;
    tick(1);
    Reset_Load_Clear = 1'b1;
    tick(3);
  endtask

  task automatic do_mul(input logic [7:0] b, input logic [7:0] s, input string tag);
    exp_t e;
    e = model(b, s, tag);
    load_b(b);
    SW  = s;
    Run = 1'b0;
    tick(12);
    request(e);
    tick(10);
    request(e);
    Run = 1'b1;
    tick(3);
    request(e);
  endtask

  initial begin
    logic [7:0] rb, rs;
    exp_t       zero_e;

    checks = 0;
    errors = 0;
    sample_req = 1'b0;
    Reset = 1'b0;
    Run = 1'b1;
    Reset_Load_Clear = 1'b1;
    SW = 8'h00;
    zero_e = make_exp(16'h0000, 1'b0, "reset");

    tick(2);
    request(zero_e);
    Reset = 1'b1;
    tick(2);
    request(zero_e);

    do_mul(8'h07, 8'h3B, "p7_x_p59");
    do_mul(8'h07, 8'hC5, "p7_x_m59");
    do_mul(8'hF9, 8'h3B, "m7_x_p59");
    do_mul(8'hF9, 8'hC5, "m7_x_m59");
    do_mul(8'h80, 8'h80, "m128_x_m128");
    do_mul(8'h7F, 8'h80, "p127_x_m128");
    do_mul(8'h80, 8'h7F, "m128_x_p127");
    do_mul(8'hFF, 8'hFF, "m1_x_m1");
    do_mul(8'h00, 8'hA5, "zero_x_s");
    do_mul(8'h7F, 8'h7F, "p127_x_p127");

    // Reset during the fourth compute cycle aborts to the reset image.
    load_b(8'h5A);
    SW  = 8'h33;
    Run = 1'b0;
    tick(6);
    Reset = 1'b0;
    #1;
    request(make_exp(16'h0000, 1'b0, "abort_in_reset"));
    Run = 1'b1;
    tick(2);
    Reset = 1'b1;
    tick(3);
    request(make_exp(16'h0000, 1'b0, "abort_after_reset"));
    do_mul(8'h5A, 8'h33, "after_abort");

    // Load/clear pulses in COMPUTE and DONE must not disturb the result.
    load_b(8'hB6);
    SW  = 8'h6D;
    Run = 1'b0;
    tick(5);
    Reset_Load_Clear = 1'b0;
    tick(2);
    Reset_Load_Clear = 1'b1;
    tick(5);
    request(model(8'hB6, 8'h6D, "rlc_in_compute"));
    tick(2);
    Reset_Load_Clear = 1'b0;
    tick(3);
    Reset_Load_Clear = 1'b1;
    tick(3);
    request(model(8'hB6, 8'h6D, "rlc_in_done"));
    Run = 1'b1;
    tick(3);
    request(model(8'hB6, 8'h6D, "rlc_back_idle"));

    for (int i = 0; i < 25; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      do_mul(rb, rs, $sformatf("rand%0d_%02h_x_%02h", i, rb, rs));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish within 2 ms");
    $fatal(1);
  end

endmodule
